// File: rtl/regfile_read_arbiter_if.sv
// Request, response and register-file port signals between the arbiter and its environment.
interface regfile_read_arbiter_if;
    logic        core_req_i;
    logic [2:0]  core_instr_type_i;
    logic [4:0]  core_rs1_i;
    logic [4:0]  core_rs2_i;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic [31:0] core_val1_o;
    logic [31:0] core_val2_o;

    logic        dbg_req_i;
    logic [4:0]  dbg_addr_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;

    logic [4:0]  rf_rs1_o;
    logic [4:0]  rf_rs2_o;
    logic        rf_valid_src1_o;
    logic        rf_valid_src2_o;
    logic [31:0] rf_val1_i;
    logic [31:0] rf_val2_i;

    logic        busy_o;

    modport slave (
        input  core_req_i, core_instr_type_i, core_rs1_i, core_rs2_i,
        output core_gnt_o, core_rvalid_o, core_val1_o, core_val2_o,
        input  dbg_req_i, dbg_addr_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output rf_rs1_o, rf_rs2_o, rf_valid_src1_o, rf_valid_src2_o,
        input  rf_val1_i, rf_val2_i,
        output busy_o
    );

    modport master (
        output core_req_i, core_instr_type_i, core_rs1_i, core_rs2_i,
        input  core_gnt_o, core_rvalid_o, core_val1_o, core_val2_o,
        output dbg_req_i, dbg_addr_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  rf_rs1_o, rf_rs2_o, rf_valid_src1_o, rf_valid_src2_o,
        output rf_val1_i, rf_val2_i,
        input  busy_o
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Core/debug arbiter for the shared register-file read ports: grant -> read -> respond, 2-cycle latency.
// No backpressure, one grant per cycle; REGARB_STARVE_GUARD_EN adds a debug starvation guard.
module regfile_read_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    regfile_read_arbiter_if.slave  bus
);
    localparam logic [2:0] TYPER = 3'd0;
    localparam logic [2:0] TYPEI = 3'd1;
    localparam logic [2:0] TYPES = 3'd2;
    localparam logic [2:0] TYPEB = 3'd3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic        starve_fire;
    logic        core_gnt;
    logic        dbg_gnt;
    logic        core_en1;
    logic        core_en2;

    logic        b_vld;
    logic        b_dbg;
    logic [4:0]  b_rs1;
    logic [4:0]  b_rs2;
    logic        b_en1;
    logic        b_en2;

    logic        core_rvalid;
    logic        dbg_rvalid;
    logic [31:0] core_val1;
    logic [31:0] core_val2;
    logic [31:0] dbg_rdata;
    logic [31:0] rd1;
    logic [31:0] rd2;

`ifdef REGARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign starve_fire = (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 4'd0;
        end else if (!bus.dbg_req_i || dbg_gnt) begin
            starve_cnt <= 4'd0;
        end else if (core_gnt) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign starve_fire = 1'b0;
`endif

    // Grants are combinational but held low while reset is asserted.
    always_comb begin
        core_gnt = !rst_i && bus.core_req_i && !(bus.dbg_req_i && starve_fire);
        dbg_gnt  = !rst_i && bus.dbg_req_i && (!bus.core_req_i || starve_fire);
    end

    always_comb begin
        core_en1 = 1'b0;
        core_en2 = 1'b0;
        case (bus.core_instr_type_i)
            TYPER, TYPES, TYPEB: begin
                core_en1 = 1'b1;
                core_en2 = 1'b1;
            end
            TYPEI: core_en1 = 1'b1;
            default: ;
        endcase
    end

    // x0 and disabled operands read as zero regardless of what the file returns.
    assign rd1 = (b_en1 && (b_rs1 != 5'd0)) ? bus.rf_val1_i : 32'h0;
    assign rd2 = (b_en2 && (b_rs2 != 5'd0)) ? bus.rf_val2_i : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_vld       <= 1'b0;
            b_dbg       <= 1'b0;
            b_rs1       <= 5'd0;
            b_rs2       <= 5'd0;
            b_en1       <= 1'b0;
            b_en2       <= 1'b0;
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            core_val1   <= 32'h0;
            core_val2   <= 32'h0;
            dbg_rdata   <= 32'h0;
        end else begin
            b_vld <= core_gnt || dbg_gnt;
            b_dbg <= dbg_gnt;
            if (dbg_gnt) begin
                b_rs1 <= bus.dbg_addr_i;
                b_rs2 <= 5'd0;
                b_en1 <= 1'b1;
                b_en2 <= 1'b0;
            end else if (core_gnt) begin
                b_rs1 <= bus.core_rs1_i;
                b_rs2 <= bus.core_rs2_i;
                b_en1 <= core_en1;
                b_en2 <= core_en2;
            end else begin
                b_rs1 <= 5'd0;
                b_rs2 <= 5'd0;
                b_en1 <= 1'b0;
                b_en2 <= 1'b0;
            end

            core_rvalid <= b_vld && !b_dbg;
            dbg_rvalid  <= b_vld && b_dbg;
            if (b_vld && !b_dbg) begin
                core_val1 <= rd1;
                core_val2 <= rd2;
            end
            if (b_vld && b_dbg) begin
                dbg_rdata <= rd1;
            end
        end
    end

    // Stage-B registers are zeroed when empty, so they drive the file ports directly.
    assign bus.core_gnt_o      = core_gnt;
    assign bus.dbg_gnt_o       = dbg_gnt;
    assign bus.rf_rs1_o        = b_rs1;
    assign bus.rf_rs2_o        = b_rs2;
    assign bus.rf_valid_src1_o = b_en1;
    assign bus.rf_valid_src2_o = b_en2;
    assign bus.core_rvalid_o   = core_rvalid;
    assign bus.core_val1_o     = core_val1;
    assign bus.core_val2_o     = core_val2;
    assign bus.dbg_rvalid_o    = dbg_rvalid;
    assign bus.dbg_rdata_o     = dbg_rdata;
    assign bus.busy_o          = b_vld || core_rvalid || dbg_rvalid;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench: per-cycle vector table plus starvation, reset and back-to-back sequences.
module tb_regfile_read_arbiter;
    localparam logic [2:0] TYPER = 3'd0;
    localparam logic [2:0] TYPEI = 3'd1;
    localparam logic [2:0] TYPES = 3'd2;
    localparam logic [2:0] TYPEB = 3'd3;
    localparam logic [2:0] TYPEX = 3'd7;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_read_arbiter_if bus();
    regfile_read_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] rf_mem [32];
    assign bus.rf_val1_i = rf_mem[bus.rf_rs1_o];
    assign bus.rf_val2_i = rf_mem[bus.rf_rs2_o];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        creq;
        logic [2:0]  ctype;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        dreq;
        logic [4:0]  daddr;
        logic        cgnt;
        logic        dgnt;
        logic [4:0]  frs1;
        logic [4:0]  frs2;
        logic        fen1;
        logic        fen2;
        logic        crv;
        logic [31:0] cv1;
        logic [31:0] cv2;
        logic        drv;
        logic [31:0] dd;
        logic        busy;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic creq, input logic [2:0] ctype, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic dreq, input logic [4:0] daddr);
        bus.core_req_i        = creq;
        bus.core_instr_type_i = ctype;
        bus.core_rs1_i        = rs1;
        bus.core_rs2_i        = rs2;
        bus.dbg_req_i         = dreq;
        bus.dbg_addr_i        = daddr;
    endtask

    task automatic idle();
        drive(1'b0, TYPER, 5'd0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + 32'(i);
        rf_mem[0] = 32'hBAD0_0000;
        rf_mem[3] = 32'h0000_00A5;
        rf_mem[5] = 32'h0000_0011;
        rf_mem[6] = 32'h0000_0022;
        rf_mem[9] = DB;

        //        creq  ctype  rs1     rs2     dreq  daddr | cgnt  dgnt  frs1    frs2    fen1  fen2  crv   cv1           cv2           drv   dd            busy
        vt[0]  = '{1'b1, TYPER, 5'd5,  5'd6,  1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0, 1'b0};
        vt[1]  = '{1'b1, TYPEI, 5'd3,  5'd7,  1'b0, 5'd0, 1'b1, 1'b0, 5'd5,  5'd6,  1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0, 1'b1};
        vt[2]  = '{1'b0, TYPER, 5'd0,  5'd0,  1'b1, 5'd0, 1'b0, 1'b1, 5'd3,  5'd7,  1'b1, 1'b0, 1'b1, 32'h11,       32'h22,       1'b0, 32'h0, 1'b1};
        vt[3]  = '{1'b0, TYPER, 5'd0,  5'd0,  1'b1, 5'd9, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 32'hA5,       32'h0,        1'b0, 32'h0, 1'b1};
        vt[4]  = '{1'b0, TYPER, 5'd0,  5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 32'hA5,       32'h0,        1'b1, 32'h0, 1'b1};
        vt[5]  = '{1'b0, TYPER, 5'd0,  5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'hA5,       32'h0,        1'b1, DB,    1'b1};
        vt[6]  = '{1'b1, TYPEX, 5'd5,  5'd6,  1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'hA5,       32'h0,        1'b0, DB,    1'b0};
        vt[7]  = '{1'b0, TYPER, 5'd0,  5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 5'd5,  5'd6,  1'b0, 1'b0, 1'b0, 32'hA5,       32'h0,        1'b0, DB,    1'b1};
        vt[8]  = '{1'b0, TYPER, 5'd0,  5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, DB,    1'b1};
        vt[9]  = '{1'b1, TYPES, 5'd10, 5'd11, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, DB,    1'b0};
        vt[10] = '{1'b1, TYPEB, 5'd0,  5'd12, 1'b0, 5'd0, 1'b1, 1'b0, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, DB,    1'b1};
        vt[11] = '{1'b0, TYPER, 5'd0,  5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd12, 1'b1, 1'b1, 1'b1, 32'h100A,     32'h100B,     1'b0, DB,    1'b1};
        vt[12] = '{1'b0, TYPER, 5'd0,  5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h0,        32'h100C,     1'b0, DB,    1'b1};
        vt[13] = '{1'b0, TYPER, 5'd0,  5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        32'h100C,     1'b0, DB,    1'b0};

        // Reset state, with a core request held to show grants stay low.
        drive(1'b1, TYPER, 5'd5, 5'd6, 1'b1, 5'd9);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_core_gnt", 32'(bus.core_gnt_o), 32'h0);
        chk("rst_dbg_gnt", 32'(bus.dbg_gnt_o), 32'h0);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_rf_rs1", 32'(bus.rf_rs1_o), 32'h0);
        chk("rst_rf_en1", 32'(bus.rf_valid_src1_o), 32'h0);
        chk("rst_core_rvalid", 32'(bus.core_rvalid_o), 32'h0);
        chk("rst_core_val1", bus.core_val1_o, 32'h0);
        chk("rst_dbg_rdata", bus.dbg_rdata_o, 32'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vt[i].creq, vt[i].ctype, vt[i].rs1, vt[i].rs2, vt[i].dreq, vt[i].daddr);
            if (i == 0) rst = 1'b0;
            #1;
            chk($sformatf("v%0d_core_gnt", i), 32'(bus.core_gnt_o), 32'(vt[i].cgnt));
            chk($sformatf("v%0d_dbg_gnt", i), 32'(bus.dbg_gnt_o), 32'(vt[i].dgnt));
            chk($sformatf("v%0d_rf_rs1", i), 32'(bus.rf_rs1_o), 32'(vt[i].frs1));
            chk($sformatf("v%0d_rf_rs2", i), 32'(bus.rf_rs2_o), 32'(vt[i].frs2));
            chk($sformatf("v%0d_rf_en1", i), 32'(bus.rf_valid_src1_o), 32'(vt[i].fen1));
            chk($sformatf("v%0d_rf_en2", i), 32'(bus.rf_valid_src2_o), 32'(vt[i].fen2));
            chk($sformatf("v%0d_core_rvalid", i), 32'(bus.core_rvalid_o), 32'(vt[i].crv));
            chk($sformatf("v%0d_core_val1", i), bus.core_val1_o, vt[i].cv1);
            chk($sformatf("v%0d_core_val2", i), bus.core_val2_o, vt[i].cv2);
            chk($sformatf("v%0d_dbg_rvalid", i), 32'(bus.dbg_rvalid_o), 32'(vt[i].drv));
            chk($sformatf("v%0d_dbg_rdata", i), bus.dbg_rdata_o, vt[i].dd);
            chk($sformatf("v%0d_busy", i), 32'(bus.busy_o), 32'(vt[i].busy));
        end

        // Both requesters held continuously.
        for (int k = 0; k < 15; k++) begin
            logic exp_dbg;
`ifdef REGARB_STARVE_GUARD_EN
            exp_dbg = ((k % 5) == 4);
`else
            exp_dbg = 1'b0;
`endif
            @(negedge clk);
            drive(1'b1, TYPER, 5'd1, 5'd2, 1'b1, 5'd3);
            #1;
            chk($sformatf("starve%0d_core_gnt", k), 32'(bus.core_gnt_o), 32'(!exp_dbg));
            chk($sformatf("starve%0d_dbg_gnt", k), 32'(bus.dbg_gnt_o), 32'(exp_dbg));
        end
        repeat (4) begin
            @(negedge clk);
            idle();
        end

        // Reset while two reads are in flight.
        @(negedge clk);
        drive(1'b1, TYPER, 5'd5, 5'd6, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, TYPER, 5'd3, 5'd9, 1'b0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_core_gnt_forced", 32'(bus.core_gnt_o), 32'h0);
        chk("mrst_first_rvalid", 32'(bus.core_rvalid_o), 32'h1);
        chk("mrst_first_val1", bus.core_val1_o, 32'h11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b0;
            idle();
            #1;
            chk($sformatf("mrst%0d_core_rvalid", k), 32'(bus.core_rvalid_o), 32'h0);
            chk($sformatf("mrst%0d_dbg_rvalid", k), 32'(bus.dbg_rvalid_o), 32'h0);
            chk($sformatf("mrst%0d_busy", k), 32'(bus.busy_o), 32'h0);
            chk($sformatf("mrst%0d_core_val1", k), bus.core_val1_o, 32'h0);
            chk($sformatf("mrst%0d_core_val2", k), bus.core_val2_o, 32'h0);
            chk($sformatf("mrst%0d_dbg_rdata", k), bus.dbg_rdata_o, 32'h0);
        end

        // Five back-to-back core reads.
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j < 5) drive(1'b1, TYPER, 5'(10 + j), 5'(15 + j), 1'b0, 5'd0);
            else idle();
            #1;
            chk($sformatf("b2b%0d_core_gnt", j), 32'(bus.core_gnt_o), 32'(j < 5));
            chk($sformatf("b2b%0d_busy", j), 32'(bus.busy_o), 32'(j >= 1 && j <= 6));
            chk($sformatf("b2b%0d_core_rvalid", j), 32'(bus.core_rvalid_o), 32'(j >= 2 && j <= 6));
            if (j >= 2 && j <= 6) begin
                chk($sformatf("b2b%0d_val1", j), bus.core_val1_o, 32'h1000 + 32'(10 + j - 2));
                chk($sformatf("b2b%0d_val2", j), bus.core_val2_o, 32'h1000 + 32'(15 + j - 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Pipelined arbiter that shares the register file's single read-port pair (rs1/rs2 addresses, per-port valid, two 32-bit read values) between the core decode path and a debug/host read requester. The arbiter sits between the requesters and `access_register_file`. It does three things:
- Grants one requester per cycle under fixed core-first priority, with an optional starvation guard for debug.
- Derives the port enables from the core's instruction type.
- Registers the read results into a 3-stage pipeline: accept, read, respond.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles debug may be denied while requesting before it is forced ahead of the core (starvation guard only); legal range 1–15.
- `clk_i` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_i` input, 1 bit: synchronous, active-high reset.
- `core_req_i` input, 1 bit: core read request; held with its operands until granted.
- `core_instr_type_i` input, 3 bits: `TYPER`/`TYPEI`/`TYPES`/`TYPEB`/other encodings from `define.v`.
- `core_rs1_i`, `core_rs2_i` input, 5 bits each: core source register indices.
- `core_gnt_o` output, 1 bit: combinational; request accepted at this clock edge.
- `core_rvalid_o` output, 1 bit: one-cycle pulse; `core_val1_o`/`core_val2_o` are valid.
- `core_val1_o`, `core_val2_o` output, 32 bits each: registered read values.
- `dbg_req_i` input, 1 bit: debug read request; held with its address until granted.
- `dbg_addr_i` input, 5 bits: debug register index.
- `dbg_gnt_o` output, 1 bit: combinational grant.
- `dbg_rvalid_o` output, 1 bit: one-cycle pulse; `dbg_rdata_o` is valid.
- `dbg_rdata_o` output, 32 bits: registered debug read value.
- `rf_rs1_o`, `rf_rs2_o` output, 5 bits each: register file read addresses.
- `rf_valid_src1_o`, `rf_valid_src2_o` output, 1 bit each: register file port enables.
- `rf_val1_i`, `rf_val2_i` input, 32 bits each: combinational register file read data.
- `busy_o` output, 1 bit: any pipeline stage occupied.

## Operation
**Arbitration**
- At most one grant per cycle. The core wins when both request, unless the starvation guard fires.
- A grant is issued in every cycle a request is present. There is no backpressure and a new grant may be issued every cycle.

**Stage A (accept)**
- On a grant, latch the owner (core or debug), the addresses and the enables into stage-B registers, and set the stage-B valid bit.
- Core enables: rs1 enabled for R/I/S/B types; rs2 enabled for R/S/B types.
- Debug: `dbg_addr_i` is used as rs1, rs1 is enabled and rs2 is disabled.

**Stage B (read)**
- While the stage-B valid bit is set, drive `rf_*` from the stage-B registers.
- When stage B is empty, `rf_*` is all zero and both enables are low.
- At the end of the cycle, capture `rf_val1_i`/`rf_val2_i` into the owner's output registers.
- A disabled operand, or an operand whose index is 0, is stored as `32'h0`.

**Stage C (respond)**
- The owner's `rvalid` pulses for exactly one cycle.
- The value outputs hold until that owner's next response.

**Other rules**
- An illegal or other instruction type is granted with both enables low; it returns val1 = val2 = 0.
- `busy_o` = stage-B valid OR stage-C valid.

## Timing
- Request sampled with grant in cycle N → `rf_*` driven in N+1 → `rvalid` high in N+2. Latency is 2 cycles; throughput is 1 read per cycle.
- Back-to-back grants to different owners produce consecutive `rvalid` pulses on the respective outputs, in grant order.
- Reset values: all outputs 0, both valid bits 0, starvation counter 0. This includes `core_gnt_o`/`dbg_gnt_o`, which are forced 0 during reset.
- Reset mid-operation: in-flight reads are discarded and no `rvalid` is produced for them. Grants resume the first cycle after `rst_i` is deasserted.
- A request that is deasserted before it is granted is simply dropped; there is no error.

## Configuration
Macro `REGARB_STARVE_GUARD_EN` controls the debug starvation guard.

With the macro defined:
- A 4-bit counter increments each cycle that `dbg_req_i` is high and the core is granted instead.
- When the counter equals `STARVE_LIMIT`, debug is granted that cycle over the core, and the counter clears.
- The counter also clears whenever debug is granted or `dbg_req_i` is low.

Without the macro:
- Strict core priority applies and the counter logic is absent. Debug can starve indefinitely.
- `STARVE_LIMIT` is ignored.

## Test plan
- After reset, hold `core_req_i` with `TYPER`, rs1=5, rs2=6, where x5=`32'h11`, x6=`32'h22` → `core_gnt_o`=1 in cycle 0; `rf_rs1_o`=5, `rf_rs2_o`=6, both enables=1 in cycle 1; `core_rvalid_o`=1 with val1=`32'h11`, val2=`32'h22` in cycle 2.
- Core `TYPEI`, rs1=3 (x3=`32'hA5`), rs2=7 → `rf_valid_src2_o`=0; val1=`32'hA5`, val2=0.
- Debug only, addr=0 → `dbg_rvalid_o`=1 two cycles after grant, `dbg_rdata_o`=0. A following debug read of addr=9 (x9=`32'hDEAD_BEEF`) returns `32'hDEAD_BEEF`.
- Core and debug both request continuously with `STARVE_LIMIT`=4:
  - With `REGARB_STARVE_GUARD_EN`: 4 core grants, then 1 debug grant, repeating.
  - Without it: debug is never granted.
- Assert `rst_i` for one cycle while two reads are in flight → no `rvalid` pulse afterwards, `busy_o`=0, and all value outputs read 0.
- Five back-to-back core grants with distinct registers → five consecutive `core_rvalid_o` pulses carrying the values in order; `busy_o` high throughout.
